bg_rom_arbiter: RTL
===================

# bg_rom_arbiter

Time-multiplexes a single background_rom read port among three requesters: the VGA pixel fetch, the Pac-Man wall-collision lookup and the ghost spawn-cell check. The arbiter drives the ROM's x/y address, tracks requests in flight through the ROM's read latency, and returns each result to the correct requester with a valid strobe and a decoded wall flag. It sits in `system` between `processor`/`ghostRand` and the shared ROM, so the design no longer needs three ROM copies.

## Interface
- ROM_LAT, 1, ROM read latency in clocks (address registered to dout valid); legal 1–4.
- WALL_COLOR, 3'd1, background color code treated as wall.
- MAX_WAIT, 15, cycles a granted-eligible low-priority request may wait before `starve_err` is flagged.

- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- vga_req  in  1  pixel fetch strobe; one-cycle pulse, never held.
- vga_x / vga_y  in  8 / 7  pixel address, sampled with vga_req.
- col_req  in  1  collision lookup request; level, held until col_ack.
- col_x / col_y  in  8 / 7  Pac-Man address; stable while col_req high.
- gh_req  in  1  ghost cell check request; level, held until gh_ack.
- gh_x / gh_y  in  8 / 7  ghost address; stable while gh_req high.
- rom_x / rom_y  out  8 / 7  address to background_rom.
- rom_dout  in  3  background_rom data.
- col_ack / gh_ack  out  1  one-cycle accept pulse.
- vga_valid / col_valid / gh_valid  out  1  one-cycle result strobe.
- vga_color  out  3  returned pixel color, held until next vga_valid.
- col_wall / gh_wall  out  1  rom_dout==WALL_COLOR at that requester's valid; held until its next valid.
- starve_err  out  1  sticky; set when a low-priority request waits more than MAX_WAIT cycles.

## Operation
- Issue cycle: exactly one address is driven to the ROM per cycle, or none (idle).
- Priority: vga_req always wins. Otherwise col and gh are granted round-robin; `last_grant` register (reset = gh, so col wins the first tie). If only one requests, it wins.
- Grant of col/gh: ack pulses in the grant cycle; rom_x/rom_y carry that requester's address in the same cycle. Requester must drop req or present a new address the cycle after ack; req still high after ack is a new request.
- Tag pipeline: a ROM_LAT-deep shift register of 2-bit tags {NONE, VGA, COL, GH} advances every cycle. The tag of the issue cycle enters stage 0; when a tag leaves the last stage, the matching *_valid pulses and its result register captures rom_dout (vga_color) or the wall compare (col_wall/gh_wall).
- Idle cycles: rom_x/rom_y hold the last driven address; tag NONE.
- Starvation: per low-priority requester, a 4-bit+ wait counter increments each cycle its req is high without ack, clears on ack or req low; count > MAX_WAIT sets starve_err (cleared only by reset). VGA is never stalled.
- Width rules: addresses are pass-through; no arithmetic on addresses. The wall compare is a 3-bit equality.

## Timing
- Reset (reset low, asynchronous): rom_x=0, rom_y=0, all acks/valids=0, vga_color=0, col_wall=0, gh_wall=0, starve_err=0, tags=NONE, wait counters=0, last_grant=gh.
- Latency: request issued in cycle N -> valid and data in cycle N+ROM_LAT; throughput one result per cycle.
- Simultaneous vga_req, col_req, gh_req: VGA issues; col and gh wait. Next cycle without vga_req serves col or gh per round-robin.
- Back-to-back vga_req every cycle: col/gh starve; starve_err sets on cycle MAX_WAIT+1 of waiting.
- Reset asserted mid-flight: in-flight tags are discarded; no valid pulses appear after reset release for pre-reset requests.
- Reset release: first grant possible on the first rising edge with reset high.

## Test plan
- Single col_req at (10,20), ROM wall there, ROM_LAT=1: col_ack cycle N, rom_x=10, rom_y=20 in N; col_valid and col_wall=1 in N+1; gh_valid, vga_valid stay 0.
- vga_req, col_req, gh_req same cycle: VGA issued cycle N, col acked N+1, gh acked N+2; valids at N+1, N+2, N+3 with data from each address.
- col_req and gh_req both held continuously, no VGA: acks alternate col, gh, col, gh starting with col after reset.
- vga_req every cycle for 20 cycles with col_req held: no col_ack, starve_err rises after 16 waiting cycles and stays high after col is served.
- ROM_LAT=3, mixed stream VGA/COL/GH/idle: each valid appears exactly 3 cycles after issue with correct tag ordering; idle cycles produce no valid.
- reset pulsed low one cycle after a gh_ack: all outputs zero immediately (asynchronous), no gh_valid after release, next grant arbitration starts from col.

Source files
------------

// File: rtl/bg_rom_arbiter_if.sv
// Shared background-ROM access bundle: three requesters, the ROM read port,
// and the per-requester result strobes.
interface bg_rom_arbiter_if;
    // VGA pixel fetch (one-cycle pulse)
    logic       vga_req;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    // Pac-Man collision lookup (level, held until ack)
    logic       col_req;
    logic [7:0] col_x;
    logic [6:0] col_y;
    // Ghost spawn-cell check (level, held until ack)
    logic       gh_req;
    logic [7:0] gh_x;
    logic [6:0] gh_y;
    // background_rom read port
    logic [7:0] rom_x;
    logic [6:0] rom_y;
    logic [2:0] rom_dout;
    // Handshake and results
    logic       col_ack;
    logic       gh_ack;
    logic       vga_valid;
    logic       col_valid;
    logic       gh_valid;
    logic [2:0] vga_color;
    logic       col_wall;
    logic       gh_wall;
    logic       starve_err;

    // System side: requesters plus the ROM data return
    modport master (
        output vga_req, vga_x, vga_y,
        output col_req, col_x, col_y,
        output gh_req, gh_x, gh_y,
        output rom_dout,
        input  rom_x, rom_y,
        input  col_ack, gh_ack,
        input  vga_valid, col_valid, gh_valid,
        input  vga_color, col_wall, gh_wall,
        input  starve_err
    );

    // Arbiter side
    modport slave (
        input  vga_req, vga_x, vga_y,
        input  col_req, col_x, col_y,
        input  gh_req, gh_x, gh_y,
        input  rom_dout,
        output rom_x, rom_y,
        output col_ack, gh_ack,
        output vga_valid, col_valid, gh_valid,
        output vga_color, col_wall, gh_wall,
        output starve_err
    );
endinterface

// File: rtl/bg_rom_arbiter.sv
// bg_rom_arbiter: time-multiplexes one background_rom read port among the
// VGA pixel fetch, the Pac-Man collision lookup and the ghost spawn check.
// VGA has absolute priority; col/gh share the rest round-robin. A tag
// pipeline as deep as the ROM latency routes each returning word to its
// requester.
module bg_rom_arbiter #(
    parameter int         ROM_LAT    = 1,
    parameter logic [2:0] WALL_COLOR = 3'd1,
    parameter int         MAX_WAIT   = 15
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    bg_rom_arbiter_if.slave bus
);
    localparam int                WAIT_W     = $clog2(MAX_WAIT + 2);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_COL, TAG_GH} tag_t;
    typedef enum logic {LG_COL, LG_GH} last_t;

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] cnt);
        if (cnt == {WAIT_W{1'b1}}) return cnt;
        return cnt + WAIT_W'(1);
    endfunction

    function automatic logic is_wall(input logic [2:0] color);
        return color == WALL_COLOR;
    endfunction

    tag_t              issue_tag;
    tag_t              tag_p [ROM_LAT];
    tag_t              tag_out;
    last_t             last_grant;
    logic [7:0]        rom_x_q;
    logic [6:0]        rom_y_q;
    logic [7:0]        rom_x_c;
    logic [6:0]        rom_y_c;
    logic [WAIT_W-1:0] col_wait;
    logic [WAIT_W-1:0] gh_wait;
    logic              col_wait_over;
    logic              gh_wait_over;
    logic [2:0]        vga_color_q;
    logic              col_wall_q;
    logic              gh_wall_q;
    logic              starve_q;

    // Choose this cycle's ROM user; nothing is granted while reset is held.
    always_comb begin
        issue_tag = TAG_NONE;
        if (reset) begin
            if (bus.vga_req)
                issue_tag = TAG_VGA;
            else if (bus.col_req && bus.gh_req)
                issue_tag = (last_grant == LG_GH) ? TAG_COL : TAG_GH;
            else if (bus.col_req)
                issue_tag = TAG_COL;
            else if (bus.gh_req)
                issue_tag = TAG_GH;
        end
    end

    // Route the winner's address to the ROM; idle cycles keep the last address.
    always_comb begin
        rom_x_c = rom_x_q;
        rom_y_c = rom_y_q;
        case (issue_tag)
            TAG_VGA: begin rom_x_c = bus.vga_x; rom_y_c = bus.vga_y; end
            TAG_COL: begin rom_x_c = bus.col_x; rom_y_c = bus.col_y; end
            TAG_GH:  begin rom_x_c = bus.gh_x;  rom_y_c = bus.gh_y;  end
            default: ;
        endcase
    end

    assign tag_out       = tag_p[ROM_LAT-1];
    assign bus.rom_x     = rom_x_c;
    assign bus.rom_y     = rom_y_c;
    assign bus.col_ack   = (issue_tag == TAG_COL);
    assign bus.gh_ack    = (issue_tag == TAG_GH);
    assign bus.vga_valid = (tag_out == TAG_VGA);
    assign bus.col_valid = (tag_out == TAG_COL);
    assign bus.gh_valid  = (tag_out == TAG_GH);
    // Results show rom_dout directly in the valid cycle, then hold it.
    assign bus.vga_color  = bus.vga_valid ? bus.rom_dout : vga_color_q;
    assign bus.col_wall   = bus.col_valid ? is_wall(bus.rom_dout) : col_wall_q;
    assign bus.gh_wall    = bus.gh_valid  ? is_wall(bus.rom_dout) : gh_wall_q;
    assign bus.starve_err = starve_q;

    assign col_wait_over = bus.col_req && !bus.col_ack && (sat_inc(col_wait) > WAIT_LIMIT);
    assign gh_wait_over  = bus.gh_req  && !bus.gh_ack  && (sat_inc(gh_wait)  > WAIT_LIMIT);

    // Issue stage -> tag stage 0: advance tags, remember address and round-robin owner.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ROM_LAT; i++) tag_p[i] <= TAG_NONE;
            last_grant <= LG_GH;
            rom_x_q    <= '0;
            rom_y_q    <= '0;
        end else begin
            tag_p[0] <= issue_tag;
            for (int i = 1; i < ROM_LAT; i++) tag_p[i] <= tag_p[i-1];
            if (issue_tag == TAG_COL) last_grant <= LG_COL;
            if (issue_tag == TAG_GH)  last_grant <= LG_GH;
            rom_x_q <= rom_x_c;
            rom_y_q <= rom_y_c;
        end
    end

    // Last tag stage -> result hold: capture the returning word for its owner.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            vga_color_q <= '0;
            col_wall_q  <= 1'b0;
            gh_wall_q   <= 1'b0;
        end else begin
            if (bus.vga_valid) vga_color_q <= bus.rom_dout;
            if (bus.col_valid) col_wall_q  <= is_wall(bus.rom_dout);
            if (bus.gh_valid)  gh_wall_q   <= is_wall(bus.rom_dout);
        end
    end

    // Count cycles each low-priority requester waits; flag starvation stickily.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            col_wait <= '0;
            gh_wait  <= '0;
            starve_q <= 1'b0;
        end else begin
            if (!bus.col_req || bus.col_ack) col_wait <= '0;
            else                             col_wait <= sat_inc(col_wait);
            if (!bus.gh_req || bus.gh_ack)   gh_wait  <= '0;
            else                             gh_wait  <= sat_inc(gh_wait);
            if (col_wait_over || gh_wait_over) starve_q <= 1'b1;
        end
    end
endmodule
